pito_mvu_sched: RTL and testbench

Per-hart MVU job scheduler for the 8-hart PITO barrel core. Accepts MVU job-start requests from the CSR unit, where each request carries the issuing hart and its CSR_MVU_COUNTDOWN value. Runs an independent countdown channel per hart, pulses the MVU start strobe for that hart, and raises the MVU interrupt (mip bit IRQ_MVU_INTR = 16, MVU_INTR cause) when the job completes. Sits between the CSR file/trap logic and the MVU array.

---
 rtl/pito_mvu_sched_if.sv | 22 ++
 rtl/pito_mvu_sched.sv | 92 +++++++++
 tb/tb_pito_mvu_sched.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pito_mvu_sched_if.sv
// Job-start request port between the CSR unit (master) and the MVU scheduler (slave).
interface pito_mvu_sched_if #(
  parameter int NUM_HARTS      = 8,
  parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS),
  parameter int CNT_WIDTH      = 32
);
  logic                      start_valid;
  logic [HART_CNT_WIDTH-1:0] start_hart;
  logic [CNT_WIDTH-1:0]      start_countdown;
  logic                      start_ready;
  logic                      start_err;

  modport master (
    output start_valid, start_hart, start_countdown,
    input  start_ready, start_err
  );

  modport slave (
    input  start_valid, start_hart, start_countdown,
    output start_ready, start_err
  );
endinterface

// File: rtl/pito_mvu_sched.sv
// Per-hart MVU job scheduler: one countdown channel per hart, start strobe on accept,
// sticky MVU interrupt pending on completion.
module pito_mvu_sched #(
  parameter int NUM_HARTS      = 8,
  parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS),
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pito_mvu_sched_if.slave           start_if,
  input  logic                      stall,
  input  logic [NUM_HARTS-1:0]      irq_en,
  input  logic [NUM_HARTS-1:0]      irq_ack,
  output logic [NUM_HARTS-1:0]      mvu_start,
  output logic [NUM_HARTS-1:0]      mvu_busy,
  output logic [NUM_HARTS-1:0]      irq_pending,
  output logic [NUM_HARTS-1:0]      mvu_irq,
  input  logic [HART_CNT_WIDTH-1:0] rd_hart,
  output logic [CNT_WIDTH-1:0]      rd_data
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e               state_q [NUM_HARTS];
  state_e               state_d [NUM_HARTS];
  logic [CNT_WIDTH-1:0] cnt_q   [NUM_HARTS];
  logic [CNT_WIDTH-1:0] cnt_d   [NUM_HARTS];
  logic [NUM_HARTS-1:0] pend_q, pend_d;
  logic [NUM_HARTS-1:0] start_q, start_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 accept;

  // A stall freezes every channel, so no new job may be launched during it either.
  assign start_if.start_ready = (state_q[start_if.start_hart] == S_IDLE) && !stall;
  assign accept               = start_if.start_valid && start_if.start_ready;
  assign start_if.start_err   = err_q;

  always_comb begin
    pend_d    = pend_q & ~irq_ack;
    start_d   = '0;
    mvu_busy  = '0;
    err_d     = start_if.start_valid && !start_if.start_ready;
    rd_data_d = cnt_q[rd_hart];
    for (int h = 0; h < NUM_HARTS; h++) begin
      state_d[h]  = state_q[h];
      cnt_d[h]    = cnt_q[h];
      mvu_busy[h] = (state_q[h] == S_RUN);
      if (accept && (start_if.start_hart == HART_CNT_WIDTH'(h))) begin
        state_d[h] = S_RUN;
        cnt_d[h]   = start_if.start_countdown;
        start_d[h] = 1'b1;
      end else if ((state_q[h] == S_RUN) && !stall) begin
        // Completion sets pending after the ack mask, so a simultaneous ack loses.
        if (cnt_q[h] != '0) begin
          cnt_d[h] = cnt_q[h] - 1'b1;
        end else begin
          state_d[h] = S_IDLE;
          pend_d[h]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        state_q[h] <= S_IDLE;
        cnt_q[h]   <= '0;
      end
      pend_q    <= '0;
      start_q   <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        state_q[h] <= state_d[h];
        cnt_q[h]   <= cnt_d[h];
      end
      pend_q    <= pend_d;
      start_q   <= start_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign mvu_start   = start_q;
  assign irq_pending = pend_q;
  assign mvu_irq     = pend_q & irq_en;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_pito_mvu_sched.sv
// Directed self-checking bench for pito_mvu_sched; expected values are hand-derived cycle by cycle.
module tb_pito_mvu_sched;
  localparam int NUM_HARTS = 8;
  localparam int CNT_WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [7:0]  irq_en, irq_ack;
  logic [7:0]  mvu_start, mvu_busy, irq_pending, mvu_irq;
  logic [2:0]  rd_hart;
  logic [31:0] rd_data;
  int          compared = 0;
  int          mismatched = 0;

  pito_mvu_sched_if #(.NUM_HARTS(NUM_HARTS), .CNT_WIDTH(CNT_WIDTH)) sif ();

  pito_mvu_sched #(.NUM_HARTS(NUM_HARTS), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_if    (sif),
    .stall       (stall),
    .irq_en      (irq_en),
    .irq_ack     (irq_ack),
    .mvu_start   (mvu_start),
    .mvu_busy    (mvu_busy),
    .irq_pending (irq_pending),
    .mvu_irq     (mvu_irq),
    .rd_hart     (rd_hart),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] hart, input logic [31:0] n);
    sif.start_valid     = valid;
    sif.start_hart      = hart;
    sif.start_countdown = n;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; irq_en = '0; irq_ack = '0; rd_hart = '0;
    applyStimulus(1'b0, 3'd0, 32'd0);
    tick(); tick();
    checkOutput("rst_start", {24'd0, mvu_start}, 32'h0);
    checkOutput("rst_busy", {24'd0, mvu_busy}, 32'h0);
    checkOutput("rst_pend", {24'd0, irq_pending}, 32'h0);
    checkOutput("rst_irq", {24'd0, mvu_irq}, 32'h0);
    checkOutput("rst_err", {31'd0, sif.start_err}, 32'h0);
    checkOutput("rst_rd", rd_data, 32'h0);
    rst_n = 1'b1;
    tick();

    // Hart 3, N = 4
    $display("[TB] hart 3 N=4");
    rd_hart = 3'd3;
    applyStimulus(1'b1, 3'd3, 32'd4);
    checkOutput("h3_ready", {31'd0, sif.start_ready}, 32'h1);
    tick();
    applyStimulus(1'b0, 3'd0, 32'd0);
    checkOutput("h3_start_t1", {24'd0, mvu_start}, 32'h08);
    checkOutput("h3_busy_t1", {24'd0, mvu_busy}, 32'h08);
    tick();
    checkOutput("h3_start_t2", {24'd0, mvu_start}, 32'h00);
    checkOutput("h3_rd_t2", rd_data, 32'd4);
    tick();
    checkOutput("h3_rd_t3", rd_data, 32'd3);
    tick(); tick();
    checkOutput("h3_busy_t5", {24'd0, mvu_busy}, 32'h08);
    checkOutput("h3_pend_t5", {24'd0, irq_pending}, 32'h00);
    tick();
    checkOutput("h3_busy_t6", {24'd0, mvu_busy}, 32'h00);
    checkOutput("h3_pend_t6", {24'd0, irq_pending}, 32'h08);
    checkOutput("h3_irq_masked", {24'd0, mvu_irq}, 32'h00);
    irq_en = 8'h08; #1;
    checkOutput("h3_irq_en", {24'd0, mvu_irq}, 32'h08);
    irq_ack = 8'h08;
    tick();
    irq_ack = '0; irq_en = '0;
    checkOutput("h3_ack", {24'd0, irq_pending}, 32'h00);

    // Hart 0 N = 2, then hart 5 N = 0
    $display("[TB] hart 0 N=2 / hart 5 N=0");
    applyStimulus(1'b1, 3'd0, 32'd2);
    tick();
    checkOutput("h0_start", {24'd0, mvu_start}, 32'h01);
    applyStimulus(1'b1, 3'd5, 32'd0);
    tick();
    applyStimulus(1'b0, 3'd0, 32'd0);
    checkOutput("h5_start", {24'd0, mvu_start}, 32'h20);
    checkOutput("h05_busy", {24'd0, mvu_busy}, 32'h21);
    tick();
    checkOutput("h05_busy_a3", {24'd0, mvu_busy}, 32'h01);
    checkOutput("h5_pend_first", {24'd0, irq_pending}, 32'h20);
    tick();
    checkOutput("h05_busy_a4", {24'd0, mvu_busy}, 32'h00);
    checkOutput("h05_pend_both", {24'd0, irq_pending}, 32'h21);
    irq_ack = 8'h21;
    tick();
    irq_ack = '0;
    checkOutput("h05_ack", {24'd0, irq_pending}, 32'h00);

    // Restart hart 2 while busy
    $display("[TB] hart 2 restart rejection");
    applyStimulus(1'b1, 3'd2, 32'd6);
    tick();
    rd_hart = 3'd2;
    applyStimulus(1'b1, 3'd2, 32'd100);
    checkOutput("h2_ready_busy", {31'd0, sif.start_ready}, 32'h0);
    tick();
    applyStimulus(1'b0, 3'd0, 32'd0);
    checkOutput("h2_err", {31'd0, sif.start_err}, 32'h1);
    checkOutput("h2_nostart", {24'd0, mvu_start}, 32'h00);
    checkOutput("h2_rd_b2", rd_data, 32'd6);
    tick();
    checkOutput("h2_err_once", {31'd0, sif.start_err}, 32'h0);
    checkOutput("h2_rd_b3", rd_data, 32'd5);
    checkOutput("h2_busy_b3", {24'd0, mvu_busy}, 32'h04);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("h2_busy_done", {24'd0, mvu_busy}, 32'h00);
    checkOutput("h2_pend", {24'd0, irq_pending}, 32'h04);
    irq_ack = 8'h04;
    tick();
    irq_ack = '0;

    // Hart 6 N = 5 with 3 stalled cycles
    $display("[TB] hart 6 N=5 with stall");
    rd_hart = 3'd6;
    applyStimulus(1'b1, 3'd6, 32'd5);
    tick();
    applyStimulus(1'b0, 3'd0, 32'd0);
    tick();
    stall = 1'b1; #1;
    checkOutput("stall_ready", {31'd0, sif.start_ready}, 32'h0);
    tick();
    checkOutput("stall_rd_c3", rd_data, 32'd4);
    checkOutput("stall_busy_c3", {24'd0, mvu_busy}, 32'h40);
    tick();
    checkOutput("stall_rd_c4", rd_data, 32'd4);
    tick();
    stall = 1'b0;
    checkOutput("stall_rd_c5", rd_data, 32'd4);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("stall_busy_c9", {24'd0, mvu_busy}, 32'h40);
    checkOutput("stall_pend_c9", {24'd0, irq_pending}, 32'h00);
    tick();
    checkOutput("stall_busy_c10", {24'd0, mvu_busy}, 32'h00);
    checkOutput("stall_pend_c10", {24'd0, irq_pending}, 32'h40);
    irq_ack = 8'h40;
    tick();
    irq_ack = '0;

    // Hart 1: ack colliding with completion
    $display("[TB] hart 1 ack collision");
    applyStimulus(1'b1, 3'd1, 32'd1);
    tick();
    applyStimulus(1'b0, 3'd0, 32'd0);
    tick();
    irq_ack = 8'h02;
    tick();
    irq_ack = '0;
    checkOutput("h1_set_wins", {24'd0, irq_pending}, 32'h02);
    irq_en = 8'h02; #1;
    checkOutput("h1_irq", {24'd0, mvu_irq}, 32'h02);
    irq_ack = 8'h02; #1;
    checkOutput("h1_irq_ackcycle", {24'd0, mvu_irq}, 32'h02);
    tick();
    irq_ack = '0;
    checkOutput("h1_irq_fall", {24'd0, mvu_irq}, 32'h00);
    checkOutput("h1_pend_clr", {24'd0, irq_pending}, 32'h00);
    irq_ack = 8'h02;
    tick();
    irq_ack = '0;
    checkOutput("h1_ack_noop", {24'd0, irq_pending}, 32'h00);
    irq_en = '0;

    // Hart 7: reset mid-job
    $display("[TB] hart 7 reset mid-job");
    applyStimulus(1'b1, 3'd7, 32'd10);
    tick();
    applyStimulus(1'b0, 3'd0, 32'd0);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("h7_rst_busy", {24'd0, mvu_busy}, 32'h00);
    checkOutput("h7_rst_start", {24'd0, mvu_start}, 32'h00);
    for (int i = 0; i < 12; i++) tick();
    checkOutput("h7_no_irq", {24'd0, irq_pending}, 32'h00);
    applyStimulus(1'b1, 3'd7, 32'd0);
    checkOutput("h7_ready", {31'd0, sif.start_ready}, 32'h1);
    tick();
    applyStimulus(1'b0, 3'd0, 32'd0);
    checkOutput("h7_start", {24'd0, mvu_start}, 32'h80);
    checkOutput("h7_busy", {24'd0, mvu_busy}, 32'h80);
    tick();
    checkOutput("h7_busy_end", {24'd0, mvu_busy}, 32'h00);
    checkOutput("h7_pend", {24'd0, irq_pending}, 32'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
